// File: rtl/dram_wq_pkg.sv
// Shared widths, record layouts and FSM encoding for the DRAM write queue.
package dram_wq_pkg;

    localparam int STRB_W = 4;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KICK   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } wq_state_t;

    // One pixel word as pushed by the combiner: {strb, data}.
    typedef struct packed {
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } wq_beat_t;

    // One burst command as pushed by the combiner: {len, addr}.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } wq_cmd_t;

    // A burst length is usable when it is non-zero and no larger than max_len.
    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/wq_fifo.sv
// First-word-fall-through FIFO with occupancy count and drop-on-full.
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter; a push against a full FIFO is discarded even if a pop
// happens in the same cycle.
module wq_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign drop    = push && full;
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // Read/write pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/dram_write_queue.sv
// Write stage between the picture combiner and the DRAM write master.
// Pixels and burst commands are buffered separately; a command is only
// replayed as a kick-started burst once all of its words are already queued,
// so the master never stalls mid-burst waiting for data.
module dram_write_queue
    import dram_wq_pkg::*;
#(
    parameter int DATA_DEPTH = 2048,
    parameter int CMD_DEPTH  = 32,
    parameter int MAX_LEN    = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [35:0] data_in,
    input  logic        data_we,
    input  logic [39:0] ctrl_in,
    input  logic        ctrl_we,
    output logic        wr_kick,
    input  logic        wr_busy,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_len,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [11:0] data_cnt,
    output logic        overflow,
    output logic        err_len,
    output logic        idle
);

    localparam int DCW = $clog2(DATA_DEPTH) + 1;
    localparam int CCW = $clog2(CMD_DEPTH) + 1;

    wq_state_t         state, state_nxt;
    wq_beat_t          data_head;
    wq_cmd_t           cmd_head;
    logic              data_empty, data_full, data_drop, data_pop;
    logic              cmd_empty, cmd_full, cmd_drop, cmd_pop;
    logic [DCW-1:0]    data_count;
    logic [CCW-1:0]    cmd_count;
    logic [LEN_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              load, bad_len, kick, valid;

    wq_fifo #(.WIDTH(STRB_W + DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (data_we),
        .wdata (data_in),
        .pop   (data_pop),
        .rdata (data_head),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count),
        .drop  (data_drop)
    );

    wq_fifo #(.WIDTH(LEN_W + ADDR_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (ctrl_we),
        .wdata (ctrl_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count),
        .drop  (cmd_drop)
    );

    // Fullness is acted on inside the FIFOs; the command count is informational.
    logic unused_ok;
    assign unused_ok = ^{cmd_count, cmd_full, data_full};

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic plus FIFO pops and per-state outputs.
    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        data_pop  = 1'b0;
        load      = 1'b0;
        bad_len   = 1'b0;
        kick      = 1'b0;
        valid     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty) begin
                    if (!len_ok(cmd_head.len, MAX_LEN)) begin
                        // Illegal command is discarded without touching data.
                        cmd_pop = 1'b1;
                        bad_len = 1'b1;
                    end else if (data_count >= DCW'(cmd_head.len)) begin
                        cmd_pop   = 1'b1;
                        load      = 1'b1;
                        state_nxt = S_KICK;
                    end
                end
            end
            S_KICK: begin
                kick      = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                valid = (beat_cnt != '0);
                if (valid && wr_ready) begin
                    data_pop = 1'b1;
                    if (beat_cnt == LEN_W'(1)) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!wr_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst address/length latch and remaining-beat counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            addr_q   <= cmd_head.addr;
            len_q    <= cmd_head.len;
            beat_cnt <= cmd_head.len;
        end else if (data_pop) begin
            beat_cnt <= beat_cnt - LEN_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            overflow <= overflow | data_drop | cmd_drop;
            err_len  <= err_len | bad_len;
        end
    end

    // Data outputs are zeroed off-beat so nothing stale leaks to the master.
    assign wr_kick  = kick;
    assign wr_valid = valid;
    assign wr_data  = valid ? data_head.data : '0;
    assign wr_strb  = valid ? data_head.strb : '0;
    assign wr_addr  = addr_q;
    assign wr_len   = len_q;
    assign data_cnt = 12'(data_count);
    assign idle     = cmd_empty && data_empty && (state == S_IDLE);

endmodule

// File: tb/tb_dram_write_queue.sv
// Self-checking bench for dram_write_queue: scoreboard queues hold expected
// burst commands and beats; a per-cycle monitor models the write master and
// pops/compares whenever the DUT kicks or transfers a beat.
module tb_dram_write_queue;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [35:0] data_in = '0;
    logic        data_we = 1'b0;
    logic [39:0] ctrl_in = '0;
    logic        ctrl_we = 1'b0;
    logic        wr_busy = 1'b0;
    logic        wr_ready = 1'b1;
    logic        wr_kick, wr_valid, overflow, err_len, idle;
    logic [31:0] wr_addr, wr_data;
    logic [7:0]  wr_len;
    logic [3:0]  wr_strb;
    logic [11:0] data_cnt;

    dram_write_queue dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .data_in  (data_in),
        .data_we  (data_we),
        .ctrl_in  (ctrl_in),
        .ctrl_we  (ctrl_we),
        .wr_kick  (wr_kick),
        .wr_busy  (wr_busy),
        .wr_addr  (wr_addr),
        .wr_len   (wr_len),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .data_cnt (data_cnt),
        .overflow (overflow),
        .err_len  (err_len),
        .idle     (idle)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [35:0] exp_beats[$];
    logic [39:0] exp_cmds[$];
    logic [39:0] cur_cmd = '0;
    int          beats_left = 0;
    int          kick_cnt = 0;
    int          kick_cyc = 0;
    int          first_valid_cyc = 0;
    bit          fv_pend = 1'b0;
    bit          bp_mode = 1'b0;
    bit          rdy_hold = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;

    // One clock of the master model: sample at the falling edge, score any
    // kick/beat against the queues, then set wr_ready/wr_busy for next edge.
    task automatic tick();
        logic [35:0] eb;
        logic [39:0] ec;
        @(negedge CLK);
        if (wr_kick === 1'b1) begin
            kick_cnt++;
            kick_cyc = cyc;
            fv_pend  = 1'b1;
            n_cmp++;
            if (exp_cmds.size() == 0) begin
                n_err++;
                $display("FAIL kick_unexpected: got {len,addr}=%h, nothing queued", {wr_len, wr_addr});
            end else begin
                ec = exp_cmds.pop_front();
                if ({wr_len, wr_addr} !== ec) begin
                    n_err++;
                    $display("FAIL kick_cmd: got %h, want %h", {wr_len, wr_addr}, ec);
                end
            end
            cur_cmd    = {wr_len, wr_addr};
            beats_left = int'(wr_len);
            wr_busy    = 1'b1;
        end
        if (wr_valid === 1'b1) begin
            if (fv_pend) begin
                first_valid_cyc = cyc;
                fv_pend = 1'b0;
            end
            n_cmp++;
            if ({wr_len, wr_addr} !== cur_cmd) begin
                n_err++;
                $display("FAIL addr_stable: got %h, want %h", {wr_len, wr_addr}, cur_cmd);
            end
            if (wr_ready) begin
                n_cmp++;
                if (exp_beats.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got %h, nothing queued", {wr_strb, wr_data});
                end else begin
                    eb = exp_beats.pop_front();
                    if ({wr_strb, wr_data} !== eb) begin
                        n_err++;
                        $display("FAIL beat_data: got %h, want %h", {wr_strb, wr_data}, eb);
                    end
                end
                beats_left--;
                if (beats_left <= 0) wr_busy = 1'b0;
            end
        end
        wr_ready = bp_mode ? 1'($urandom_range(0, 1)) : rdy_hold;
    endtask

    task automatic push_data(input int n, input bit rnd, input bit track, output int last_cyc);
        logic [35:0] w;
        last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            w = rnd ? {4'($urandom), $urandom} : {4'hF, 32'(i)};
            data_in  = w;
            data_we  = 1'b1;
            last_cyc = cyc;
            if (track) exp_beats.push_back(w);
        end
        tick();
        data_we = 1'b0;
    endtask

    task automatic push_cmd(input int len, input int addr, input bit track, output int drv_cyc);
        tick();
        ctrl_in = {8'(len), 32'(addr)};
        ctrl_we = 1'b1;
        drv_cyc = cyc;
        if (track) exp_cmds.push_back({8'(len), 32'(addr)});
        tick();
        ctrl_we = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        bit done;
        do begin
            tick();
            n++;
            done = (idle === 1'b1) && (exp_beats.size() == 0) && (exp_cmds.size() == 0);
        end while (!done && n < budget);
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: idle=%b beats_left=%0d cmds_left=%0d after %0d cycles, want drained",
                     name, idle, exp_beats.size(), exp_cmds.size(), n);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({wr_kick, wr_valid, overflow, err_len, idle} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_flags: got kick,valid,ovf,err,idle=%b, want 00001",
                     {wr_kick, wr_valid, overflow, err_len, idle});
        end
        n_cmp++;
        if ({data_cnt, wr_addr, wr_len, wr_data, wr_strb} !== '0) begin
            n_err++;
            $display("FAIL reset_fields: got cnt=%h addr=%h len=%h data=%h strb=%h, want all 0",
                     data_cnt, wr_addr, wr_len, wr_data, wr_strb);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        int lc, cc, k0;
        push_data(64, 1'b0, 1'b1, lc);
        k0 = kick_cnt;
        push_cmd(64, 'h1000, 1'b1, cc);
        wait_done(400, "single");
        n_cmp++;
        if (kick_cnt - k0 !== 1) begin
            n_err++;
            $display("FAIL single_kicks: got %0d, want 1", kick_cnt - k0);
        end
        n_cmp++;
        if (kick_cyc !== cc + 2) begin
            n_err++;
            $display("FAIL single_kick_latency: got cycle %0d, want %0d", kick_cyc, cc + 2);
        end
        n_cmp++;
        if (idle !== 1'b1 || data_cnt !== 12'd0) begin
            n_err++;
            $display("FAIL single_idle: got idle=%b cnt=%0d, want idle=1 cnt=0", idle, data_cnt);
        end
    endtask

    task automatic test_cmd_first();
        int lc, cc, k0;
        k0 = kick_cnt;
        push_cmd(64, 'h100, 1'b1, cc);
        push_data(64, 1'b1, 1'b1, lc);
        wait_done(400, "cmd_first");
        n_cmp++;
        if (kick_cnt - k0 !== 1 || kick_cyc !== lc + 2) begin
            n_err++;
            $display("FAIL cmd_first_kick: got %0d kicks at cycle %0d, want 1 at %0d",
                     kick_cnt - k0, kick_cyc, lc + 2);
        end
        n_cmp++;
        if (first_valid_cyc !== kick_cyc + 1) begin
            n_err++;
            $display("FAIL cmd_first_valid: got first valid at %0d, want %0d", first_valid_cyc, kick_cyc + 1);
        end
    endtask

    task automatic test_full_line();
        int lc, cc, k0;
        push_data(1600, 1'b1, 1'b1, lc);
        k0 = kick_cnt;
        for (int i = 0; i < 25; i++) push_cmd(64, i * 'h100, 1'b1, cc);
        wait_done(6000, "full_line");
        n_cmp++;
        if (kick_cnt - k0 !== 25 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_line: got %0d kicks ovf=%b, want 25 kicks ovf=0", kick_cnt - k0, overflow);
        end
    endtask

    task automatic test_backpressure();
        int lc, cc, k0;
        bp_mode = 1'b1;
        push_data(57, 1'b1, 1'b1, lc);
        k0 = kick_cnt;
        push_cmd(16, 'h4000, 1'b1, cc);
        push_cmd(40, 'h4400, 1'b1, cc);
        push_cmd(1, 'h4800, 1'b1, cc);
        wait_done(2000, "backpressure");
        bp_mode = 1'b0;
        n_cmp++;
        if (kick_cnt - k0 !== 3) begin
            n_err++;
            $display("FAIL bp_kicks: got %0d, want 3", kick_cnt - k0);
        end
    endtask

    task automatic test_illegal_len();
        int lc, cc, k0;
        push_data(10, 1'b1, 1'b1, lc);
        k0 = kick_cnt;
        push_cmd(0, 'h5000, 1'b0, cc);
        push_cmd(65, 'h5100, 1'b0, cc);
        repeat (4) tick();
        n_cmp++;
        if (err_len !== 1'b1 || kick_cnt !== k0 || data_cnt !== 12'd10) begin
            n_err++;
            $display("FAIL illegal_len: got err=%b kicks=%0d cnt=%0d, want err=1 kicks=%0d cnt=10",
                     err_len, kick_cnt, data_cnt, k0);
        end
        push_cmd(10, 'h5200, 1'b1, cc);
        wait_done(200, "after_illegal");
        n_cmp++;
        if (kick_cnt !== k0 + 1) begin
            n_err++;
            $display("FAIL after_illegal_kick: got %0d kicks, want %0d", kick_cnt, k0 + 1);
        end
    endtask

    task automatic test_overflow_reset();
        int lc, cc, k0;
        push_data(2049, 1'b1, 1'b0, lc);
        tick();
        n_cmp++;
        if (overflow !== 1'b1 || data_cnt !== 12'd2048 || err_len !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got ovf=%b cnt=%0d err=%b, want ovf=1 cnt=2048 err=1",
                     overflow, data_cnt, err_len);
        end
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        n_cmp++;
        if ({overflow, err_len, idle} !== 3'b001 || data_cnt !== 12'd0) begin
            n_err++;
            $display("FAIL reset_clears: got ovf,err,idle=%b cnt=%0d, want 001 cnt=0",
                     {overflow, err_len, idle}, data_cnt);
        end
        // Stall the master so the burst sits in the streaming state.
        rdy_hold = 1'b0;
        push_data(8, 1'b1, 1'b1, lc);
        k0 = kick_cnt;
        push_cmd(8, 'h6000, 1'b1, cc);
        for (int i = 0; i < 20 && kick_cnt == k0; i++) tick();
        repeat (3) tick();
        n_cmp++;
        if (kick_cnt !== k0 + 1 || wr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_stream: got kicks=%0d valid=%b, want kicks=%0d valid=1",
                     kick_cnt, wr_valid, k0 + 1);
        end
        #2 RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({wr_kick, wr_valid, overflow, err_len, idle} !== 5'b00001) begin
            n_err++;
            $display("FAIL async_reset_flags: got kick,valid,ovf,err,idle=%b, want 00001",
                     {wr_kick, wr_valid, overflow, err_len, idle});
        end
        n_cmp++;
        if ({data_cnt, wr_addr, wr_len, wr_data, wr_strb} !== '0) begin
            n_err++;
            $display("FAIL async_reset_fields: got cnt=%h addr=%h len=%h data=%h strb=%h, want all 0",
                     data_cnt, wr_addr, wr_len, wr_data, wr_strb);
        end
        exp_beats.delete();
        exp_cmds.delete();
        wr_busy  = 1'b0;
        rdy_hold = 1'b1;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_cmd_first();
        test_full_line();
        test_backpressure();
        test_illegal_len();
        test_overflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
